// File: rtl/mixcolumn_stream.sv
// ---------------------------------------------------------------------------
// mixcolumn_stream -- byte-serial MixColumns engine, LANES columns in parallel
//
// Each lane receives one state column as four beats (row 0..3). It folds each
// beat's GF(2^8) partial products into an accumulator bank. A finished column
// moves to an output bank, and the output bank streams b_0..b_3 back out. The
// two banks let the next column fill while the previous one drains.
//
// Ports:
//   clk        clock, rising edge
//   rst_n      synchronous active-low reset
//   in_valid   input beat valid
//   in_ready   engine can take an input beat (register-only: !acc_full)
//   din        8*LANES, lane k at [8k+7:8k], beat j carries row a_j
//   inv        1 = InvMixColumns, sampled on beat 0 of each column
//   out_valid  output beat valid
//   out_ready  downstream accepts output beat
//   dout       8*LANES, beat j carries b_j (muxed from bank registers only)
//   out_last   high with beat 3 of each output column
//
// Build option: MIXCOLUMN_INV_EN compiles in the inverse multipliers. Without
// it only the forward transform exists, and inv is accepted but ignored.
// ---------------------------------------------------------------------------

// Per-lane partial products: the contribution of input row row_i to each of
// the four outputs b_0..b_3.
module mixcolumn_lane (
    input  logic [7:0]      a_i,
    input  logic [1:0]      row_i,
    input  logic            inv_i,
    output logic [3:0][7:0] p_o
);
    function automatic logic [7:0] xt(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    logic [7:0] m2;
    assign m2 = xt(a_i);

`ifdef MIXCOLUMN_INV_EN
    logic [7:0] m4, m8;
    assign m4 = xt(m2);
    assign m8 = xt(m4);
`else
    logic unused_inv;
    assign unused_inv = inv_i;
`endif

    // b_i collects a_j with the coefficient picked by d = (j - i) mod 4.
    always_comb begin
        logic [1:0] d;
        d   = 2'd0;
        p_o = '0;
        for (int i = 0; i < 4; i++) begin
            d = row_i - 2'(i);
`ifdef MIXCOLUMN_INV_EN
            if (inv_i) begin
                case (d)
                    2'd0:    p_o[i] = m8 ^ m4 ^ m2;   // 0e
                    2'd1:    p_o[i] = m8 ^ m2 ^ a_i;  // 0b
                    2'd2:    p_o[i] = m8 ^ m4 ^ a_i;  // 0d
                    default: p_o[i] = m8 ^ a_i;       // 09
                endcase
            end else
`endif
            begin
                case (d)
                    2'd0:    p_o[i] = m2;             // 02
                    2'd1:    p_o[i] = m2 ^ a_i;       // 03
                    default: p_o[i] = a_i;            // 01
                endcase
            end
        end
    end
endmodule

module mixcolumn_stream #(
    parameter int LANES = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [8*LANES-1:0] din,
    input  logic               inv,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [8*LANES-1:0] dout,
    output logic               out_last
);
    logic [1:0] in_cnt_q, out_cnt_q;
    logic       acc_full_q, out_valid_q, mode_q, mode_eff;
    logic [LANES-1:0][3:0][7:0] acc_q, obank_q, prod, col;

    logic in_fire, out_fire, out_last_fire, obank_free, load_new, load_held;

    assign in_ready      = !acc_full_q;
    assign in_fire       = in_valid && !acc_full_q;
    assign out_fire      = out_valid_q && out_ready;
    assign out_last_fire = out_fire && (out_cnt_q == 2'd3);
    // The output bank can take a column if it is empty or drains its last beat now.
    assign obank_free    = !out_valid_q || out_last_fire;
    assign load_new      = in_fire && (in_cnt_q == 2'd3) && obank_free;
    assign load_held     = acc_full_q && out_last_fire;

    // Beat 0 uses inv directly so the mode is already right for its products.
    assign mode_eff = (in_cnt_q == 2'd0) ? inv : mode_q;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        mixcolumn_lane u_lane (
            .a_i   (din[8*k +: 8]),
            .row_i (in_cnt_q),
            .inv_i (mode_eff),
            .p_o   (prod[k])
        );
    end

    // Beat 0 starts a fresh sum. Later beats add into the bank.
    always_comb begin
        col = '0;
        for (int k = 0; k < LANES; k++)
            for (int i = 0; i < 4; i++)
                col[k][i] = ((in_cnt_q == 2'd0) ? 8'h00 : acc_q[k][i]) ^ prod[k][i];
    end

    always_comb begin
        dout = '0;
        for (int k = 0; k < LANES; k++)
            dout[8*k +: 8] = obank_q[k][out_cnt_q];
    end

    assign out_valid = out_valid_q;
    assign out_last  = out_valid_q && (out_cnt_q == 2'd3);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            in_cnt_q    <= 2'd0;
            out_cnt_q   <= 2'd0;
            acc_full_q  <= 1'b0;
            out_valid_q <= 1'b0;
            mode_q      <= 1'b0;
            acc_q       <= '0;
            obank_q     <= '0;
        end else begin
            if (in_fire) begin
                in_cnt_q <= in_cnt_q + 2'd1;
                acc_q    <= col;
                if (in_cnt_q == 2'd0) mode_q <= inv;
            end
            if (out_fire) out_cnt_q <= out_cnt_q + 2'd1;

            if (load_new) begin
                obank_q     <= col;
                out_valid_q <= 1'b1;
            end else if (load_held) begin
                obank_q     <= acc_q;
                out_valid_q <= 1'b1;
                acc_full_q  <= 1'b0;
            end else if (out_last_fire) begin
                out_valid_q <= 1'b0;
            end

            // Column finished but the output bank is still busy: park it.
            if (in_fire && (in_cnt_q == 2'd3) && !obank_free)
                acc_full_q <= 1'b1;
        end
    end
endmodule
